// File: rtl/ppu_bus_pkg.sv
// Shared types and constants for the picoPPU host-side bus master.
package ppu_bus_pkg;

    localparam int DATA_W    = 8;
    localparam int SEL_W     = 3;
    localparam int DMA_CNT_W = 9;

    // Default PPU register map entries used by the master
    localparam logic [SEL_W-1:0] REG_PPUCTRL = 3'd0;
    localparam logic [SEL_W-1:0] REG_OAMADDR = 3'd3;
    localparam logic [SEL_W-1:0] REG_OAMDATA = 3'd4;

    // Bus-cycle timing generator states
    typedef enum logic [1:0] {
        CYC_IDLE,
        CYC_SETUP,
        CYC_STROBE,
        CYC_HOLD
    } cyc_state_t;

    // Arbitration / DMA sequencer states
    typedef enum logic [2:0] {
        M_IDLE,
        M_HOST,
        M_FETCH,
        M_CAPTURE,
        M_DMA
    } mst_state_t;

    // Index of the last data byte of a burst, in byte-counter width
    function automatic logic [DMA_CNT_W-1:0] last_byte_idx(input int len);
        return DMA_CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/ppu_bus_cycle.sv
// One 65C02-style bus cycle: SETUP (phi2 low, cs asserted), STROBE (phi2 high),
// HOLD (cs released, write data still driven). All pin outputs are registered.
module ppu_bus_cycle
    import ppu_bus_pkg::*;
#(
    parameter int PHI2_LO_CYCLES = 4,
    parameter int PHI2_HI_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              start_rw,
    input  logic [SEL_W-1:0]  start_reg,
    input  logic [DATA_W-1:0] start_wdata,
    output logic              cyc_done,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              bus_phi2,
    output logic              bus_cs,
    output logic              bus_cs_b,
    output logic              bus_we_b,
    output logic [SEL_W-1:0]  bus_reg_sel,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_doe,
    input  logic [DATA_W-1:0] bus_din
);

    localparam int MAX_PH = (PHI2_LO_CYCLES > PHI2_HI_CYCLES) ? PHI2_LO_CYCLES : PHI2_HI_CYCLES;
    localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
    localparam logic [PH_W-1:0] LO_LAST = PH_W'(PHI2_LO_CYCLES - 1);
    localparam logic [PH_W-1:0] HI_LAST = PH_W'(PHI2_HI_CYCLES - 1);

    cyc_state_t        state_q, state_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic              rw_q, rw_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              phi2_q, phi2_d;
    logic              cs_q, cs_d;
    logic              we_b_q, we_b_d;
    logic              doe_q, doe_d;
    logic              rd_valid_q, rd_valid_d;

    // Phase sequencing; pin values are derived from the next state so they change with it
    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        rw_d     = rw_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            CYC_IDLE: begin
                if (start) begin
                    state_d  = CYC_SETUP;
                    ph_cnt_d = '0;
                    rw_d     = start_rw;
                    sel_d    = start_reg;
                    if (!start_rw) begin
                        wdata_d = start_wdata;
                    end
                end
            end
            CYC_SETUP: begin
                if (ph_cnt_q == LO_LAST) begin
                    state_d  = CYC_STROBE;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            CYC_STROBE: begin
                if (ph_cnt_q == HI_LAST) begin
                    state_d  = CYC_HOLD;
                    ph_cnt_d = '0;
                    // PPU data is sampled on the last phi2-high clock
                    if (rw_q) begin
                        rdata_d = bus_din;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            CYC_HOLD: begin
                state_d = CYC_IDLE;
            end
            default: begin
                state_d = CYC_IDLE;
            end
        endcase

        phi2_d     = (state_d == CYC_STROBE);
        cs_d       = (state_d == CYC_SETUP) || (state_d == CYC_STROBE);
        we_b_d     = !(cs_d && !rw_d);
        doe_d      = !rw_d && (state_d != CYC_IDLE);
        rd_valid_d = rw_d && (state_d == CYC_HOLD);
    end

    // State, latched request fields and registered pin outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CYC_IDLE;
            ph_cnt_q   <= '0;
            rw_q       <= 1'b1;
            sel_q      <= REG_PPUCTRL;
            wdata_q    <= '0;
            rdata_q    <= '0;
            phi2_q     <= 1'b0;
            cs_q       <= 1'b0;
            we_b_q     <= 1'b1;
            doe_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            rw_q       <= rw_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            phi2_q     <= phi2_d;
            cs_q       <= cs_d;
            we_b_q     <= we_b_d;
            doe_q      <= doe_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign cyc_done    = (state_q == CYC_HOLD);
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rdata_q;
    assign bus_phi2    = phi2_q;
    assign bus_cs      = cs_q;
    assign bus_cs_b    = ~cs_q;
    assign bus_we_b    = we_b_q;
    assign bus_reg_sel = sel_q;
    assign bus_dout    = wdata_q;
    assign bus_doe     = doe_q;

endmodule

// File: rtl/ppu_bus_master.sv
// Host-side picoPPU register-port master: arbitrates single host accesses against
// an OAM DMA engine (manual or NMI-triggered) and drives one bus cycle at a time.
module ppu_bus_master
    import ppu_bus_pkg::*;
#(
    parameter int               PHI2_LO_CYCLES = 4,
    parameter int               PHI2_HI_CYCLES = 4,
    parameter int               DMA_LEN        = 256,
    parameter logic [SEL_W-1:0] OAMADDR_REG    = REG_OAMADDR,
    parameter logic [SEL_W-1:0] OAMDATA_REG    = REG_OAMDATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [SEL_W-1:0]  req_reg,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              dma_start,
    input  logic              dma_auto_en,
    output logic              dma_busy,
    output logic              dma_done,
    input  logic              nmi_n,
    output logic [7:0]        src_addr,
    output logic              src_en,
    input  logic [DATA_W-1:0] src_data,
    output logic              bus_phi2,
    output logic              bus_cs,
    output logic              bus_cs_b,
    output logic              bus_we_b,
    output logic [SEL_W-1:0]  bus_reg_sel,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_doe,
    input  logic [DATA_W-1:0] bus_din
);

    mst_state_t            state_q, state_d;
    logic                  dma_busy_q, dma_busy_d;
    logic                  dma_done_q, dma_done_d;
    logic                  addr_phase_q, addr_phase_d;
    logic [DMA_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]            src_addr_q, src_addr_d;
    logic                  rdy_en_q, rdy_en_d;
    logic                  nmi_s1_q, nmi_s1_d;
    logic                  nmi_s2_q, nmi_s2_d;
    logic                  nmi_prev_q, nmi_prev_d;

    logic                  nmi_fall;
    logic                  dma_trig;
    logic                  ready_int;
    logic                  cyc_start;
    logic                  cyc_rw;
    logic [SEL_W-1:0]      cyc_reg;
    logic [DATA_W-1:0]     cyc_wdata;
    logic                  cyc_done;

    assign nmi_fall = nmi_prev_q & ~nmi_s2_q;
    assign dma_trig = dma_start | (dma_auto_en & nmi_fall);
    // A DMA request in the same cycle wins over the host, so it masks ready combinationally
    assign ready_int = rdy_en_q && (state_q == M_IDLE) && !dma_busy_q && !dma_done_q && !dma_trig;

    // Arbitration, DMA sequencing and NMI edge detection
    always_comb begin
        state_d      = state_q;
        dma_busy_d   = dma_busy_q;
        dma_done_d   = 1'b0;
        addr_phase_d = addr_phase_q;
        byte_cnt_d   = byte_cnt_q;
        src_addr_d   = src_addr_q;
        rdy_en_d     = 1'b1;
        nmi_s1_d     = nmi_n;
        nmi_s2_d     = nmi_s1_q;
        nmi_prev_d   = nmi_s2_q;
        cyc_start    = 1'b0;
        cyc_rw       = req_rw;
        cyc_reg      = req_reg;
        cyc_wdata    = req_wdata;

        // Triggers while a burst is active are dropped
        if (dma_trig && !dma_busy_q) begin
            dma_busy_d   = 1'b1;
            addr_phase_d = 1'b1;
            byte_cnt_d   = '0;
            src_addr_d   = 8'h00;
        end

        case (state_q)
            M_IDLE: begin
                if (dma_busy_q) begin
                    if (addr_phase_q) begin
                        cyc_start = 1'b1;
                        cyc_rw    = 1'b0;
                        cyc_reg   = OAMADDR_REG;
                        cyc_wdata = '0;
                        state_d   = M_DMA;
                    end else begin
                        state_d = M_FETCH;
                    end
                end else if (req_valid && ready_int) begin
                    cyc_start = 1'b1;
                    state_d   = M_HOST;
                end
            end
            M_HOST: begin
                if (cyc_done) begin
                    state_d = M_IDLE;
                end
            end
            M_FETCH: begin
                state_d = M_CAPTURE;
            end
            M_CAPTURE: begin
                // src_data answers the previous cycle's src_en
                cyc_start  = 1'b1;
                cyc_rw     = 1'b0;
                cyc_reg    = OAMDATA_REG;
                cyc_wdata  = src_data;
                src_addr_d = src_addr_q + 8'd1;
                state_d    = M_DMA;
            end
            M_DMA: begin
                if (cyc_done) begin
                    if (addr_phase_q) begin
                        addr_phase_d = 1'b0;
                        state_d      = M_FETCH;
                    end else if (byte_cnt_q == last_byte_idx(DMA_LEN)) begin
                        dma_busy_d = 1'b0;
                        dma_done_d = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = M_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + DMA_CNT_W'(1);
                        state_d    = M_FETCH;
                    end
                end
            end
            default: begin
                state_d = M_IDLE;
            end
        endcase
    end

    // Sequencer state and NMI synchroniser registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= M_IDLE;
            dma_busy_q   <= 1'b0;
            dma_done_q   <= 1'b0;
            addr_phase_q <= 1'b0;
            byte_cnt_q   <= '0;
            src_addr_q   <= 8'h00;
            rdy_en_q     <= 1'b0;
            nmi_s1_q     <= 1'b1;
            nmi_s2_q     <= 1'b1;
            nmi_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            dma_busy_q   <= dma_busy_d;
            dma_done_q   <= dma_done_d;
            addr_phase_q <= addr_phase_d;
            byte_cnt_q   <= byte_cnt_d;
            src_addr_q   <= src_addr_d;
            rdy_en_q     <= rdy_en_d;
            nmi_s1_q     <= nmi_s1_d;
            nmi_s2_q     <= nmi_s2_d;
            nmi_prev_q   <= nmi_prev_d;
        end
    end

    ppu_bus_cycle #(
        .PHI2_LO_CYCLES (PHI2_LO_CYCLES),
        .PHI2_HI_CYCLES (PHI2_HI_CYCLES)
    ) u_cycle (
        .clk         (clk),
        .reset       (reset),
        .start       (cyc_start),
        .start_rw    (cyc_rw),
        .start_reg   (cyc_reg),
        .start_wdata (cyc_wdata),
        .cyc_done    (cyc_done),
        .rd_valid    (rsp_valid),
        .rd_data     (rsp_rdata),
        .bus_phi2    (bus_phi2),
        .bus_cs      (bus_cs),
        .bus_cs_b    (bus_cs_b),
        .bus_we_b    (bus_we_b),
        .bus_reg_sel (bus_reg_sel),
        .bus_dout    (bus_dout),
        .bus_doe     (bus_doe),
        .bus_din     (bus_din)
    );

    assign req_ready = ready_int;
    assign dma_busy  = dma_busy_q;
    assign dma_done  = dma_done_q;
    assign src_addr  = src_addr_q;
    assign src_en    = (state_q == M_FETCH);

endmodule

// File: tb/tb_ppu_bus_master.sv
// Directed bench for ppu_bus_master: host access table, DMA bursts, NMI trigger,
// host/DMA priority and asynchronous reset mid-cycle.
module tb_ppu_bus_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [2:0] req_reg = 3'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       dma_start = 1'b0;
    logic       dma_auto_en = 1'b0;
    logic       dma_busy;
    logic       dma_done;
    logic       nmi_n = 1'b1;
    logic [7:0] src_addr;
    logic       src_en;
    logic [7:0] src_data = 8'h00;
    logic       bus_phi2;
    logic       bus_cs;
    logic       bus_cs_b;
    logic       bus_we_b;
    logic [2:0] bus_reg_sel;
    logic [7:0] bus_dout;
    logic       bus_doe;
    logic [7:0] bus_din;
    logic [7:0] ppu_val = 8'h00;
    logic [7:0] src_mem [0:255];

    ppu_bus_master #(
        .PHI2_LO_CYCLES (4),
        .PHI2_HI_CYCLES (4),
        .DMA_LEN        (256),
        .OAMADDR_REG    (3'd3),
        .OAMDATA_REG    (3'd4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .dma_start(dma_start), .dma_auto_en(dma_auto_en),
        .dma_busy(dma_busy), .dma_done(dma_done), .nmi_n(nmi_n),
        .src_addr(src_addr), .src_en(src_en), .src_data(src_data),
        .bus_phi2(bus_phi2), .bus_cs(bus_cs), .bus_cs_b(bus_cs_b),
        .bus_we_b(bus_we_b), .bus_reg_sel(bus_reg_sel), .bus_dout(bus_dout),
        .bus_doe(bus_doe), .bus_din(bus_din)
    );

    always #5 clk = ~clk;

    // PPU model: drives read data only while selected, phi2 high and reading
    assign bus_din = (bus_cs && bus_phi2 && bus_we_b) ? ppu_val : 8'h00;

    // Source buffer with one-cycle read latency
    always @(posedge clk) begin
        if (src_en) src_data <= src_mem[src_addr];
    end

    int n_checks = 0;
    int n_fail = 0;
    int n_src_en = 0;
    int n_done = 0;
    int n_rsp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       we_b;
        logic [2:0] sel;
        logic [7:0] data;
    } bus_ev_t;
    bus_ev_t ev_q[$];

    logic       prev_phi2 = 1'b0;
    logic       st_we_b = 1'b1;
    logic [2:0] st_sel = 3'd0;
    logic [7:0] st_data = 8'h00;

    // Bus monitor: logs each completed bus cycle at the phi2 falling edge
    always @(negedge clk) begin
        if (reset) begin
            prev_phi2 = 1'b0;
        end else begin
            check("cs_b_complement", {31'd0, bus_cs_b}, {31'd0, ~bus_cs});
            if (bus_cs && bus_we_b && bus_doe) check("doe_in_read", 32'd1, 32'd0);
            if (bus_phi2) begin
                st_we_b = bus_we_b;
                st_sel  = bus_reg_sel;
                st_data = bus_we_b ? bus_din : bus_dout;
            end
            if (prev_phi2 && !bus_phi2) begin
                ev_q.push_back('{st_we_b, st_sel, st_data});
                $display("bus cycle %0d: we_b=%0d reg=%0d data=%02h", ev_q.size(), st_we_b, st_sel, st_data);
            end
            if (src_en) n_src_en++;
            if (dma_done) n_done++;
            if (rsp_valid) n_rsp++;
            prev_phi2 = bus_phi2;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, {24'd0, rsp_rdata}, 32'd0);
        check({tag, "_dma_busy"}, {31'd0, dma_busy}, 32'd0);
        check({tag, "_dma_done"}, {31'd0, dma_done}, 32'd0);
        check({tag, "_src_en"}, {31'd0, src_en}, 32'd0);
        check({tag, "_src_addr"}, {24'd0, src_addr}, 32'd0);
        check({tag, "_phi2"}, {31'd0, bus_phi2}, 32'd0);
        check({tag, "_cs"}, {31'd0, bus_cs}, 32'd0);
        check({tag, "_cs_b"}, {31'd0, bus_cs_b}, 32'd1);
        check({tag, "_we_b"}, {31'd0, bus_we_b}, 32'd1);
        check({tag, "_reg_sel"}, {29'd0, bus_reg_sel}, 32'd0);
        check({tag, "_dout"}, {24'd0, bus_dout}, 32'd0);
        check({tag, "_doe"}, {31'd0, bus_doe}, 32'd0);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d;
        d = n_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done != d) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One host access with per-cycle pin checks; k counts clocks after the accept cycle
    task automatic do_host(input int idx, input logic rw, input logic [2:0] sel,
                           input logic [7:0] wdata, input logic [7:0] pval, input logic [7:0] exp_rd);
        bit ok;
        int n0;
        string p;
        p = $sformatf("v%0d", idx);
        ppu_val = pval;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_rw    = rw;
        req_reg   = sel;
        req_wdata = wdata;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({p, "_accept"}, {31'd0, ok}, 32'd1);
        n0 = ev_q.size();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("%s_phi2_k%0d", p, k), {31'd0, bus_phi2}, {31'd0, (k >= 5 && k <= 8)});
            check($sformatf("%s_cs_k%0d", p, k), {31'd0, bus_cs}, {31'd0, (k <= 8)});
            check($sformatf("%s_we_b_k%0d", p, k), {31'd0, bus_we_b}, {31'd0, (rw || k >= 9)});
            check($sformatf("%s_doe_k%0d", p, k), {31'd0, bus_doe}, {31'd0, (!rw && k <= 9)});
            check($sformatf("%s_rsp_valid_k%0d", p, k), {31'd0, rsp_valid}, {31'd0, (rw && k == 9)});
            check($sformatf("%s_req_ready_k%0d", p, k), {31'd0, req_ready}, {31'd0, (k == 10)});
            if (k <= 8) check($sformatf("%s_reg_sel_k%0d", p, k), {29'd0, bus_reg_sel}, {29'd0, sel});
            if (!rw && k <= 9) check($sformatf("%s_dout_k%0d", p, k), {24'd0, bus_dout}, {24'd0, wdata});
            if (rw && k >= 9) check($sformatf("%s_rdata_k%0d", p, k), {24'd0, rsp_rdata}, {24'd0, exp_rd});
        end
        check({p, "_ev_count"}, ev_q.size(), n0 + 1);
        if (ev_q.size() == n0 + 1) begin
            check({p, "_ev_we_b"}, {31'd0, ev_q[n0].we_b}, {31'd0, rw});
            check({p, "_ev_sel"}, {29'd0, ev_q[n0].sel}, {29'd0, sel});
            check({p, "_ev_data"}, {24'd0, ev_q[n0].data}, {24'd0, rw ? pval : wdata});
        end
        $display("host %s rw=%0d reg=%0d wdata=%02h rdata=%02h", p, rw, sel, wdata, rsp_rdata);
    endtask

    // Checks a logged DMA burst starting at queue index base
    task automatic check_burst(input string tag, input int base);
        check({tag, "_addr_sel"}, {29'd0, ev_q[base].sel}, 32'd3);
        check({tag, "_addr_we_b"}, {31'd0, ev_q[base].we_b}, 32'd0);
        check({tag, "_addr_data"}, {24'd0, ev_q[base].data}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ib;
            ib = i[7:0];
            check($sformatf("%s_b%0d_sel", tag, i), {29'd0, ev_q[base + 1 + i].sel}, 32'd4);
            check($sformatf("%s_b%0d_data", tag, i), {24'd0, ev_q[base + 1 + i].data}, {24'd0, ib ^ 8'h55});
        end
    endtask

    typedef struct {
        logic       rw;
        logic [2:0] sel;
        logic [7:0] wdata;
        logic [7:0] pval;
        logic [7:0] exp_rd;
    } host_vec_t;
    host_vec_t vecs[6];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n0, d0, s0, r0, bad;
        bit seen, acc;

        vecs[0] = '{1'b0, 3'd2, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 3'd5, 8'h00, 8'h3C, 8'h3C};
        vecs[2] = '{1'b0, 3'd7, 8'h5A, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 3'd0, 8'h11, 8'hC3, 8'hC3};
        vecs[4] = '{1'b0, 3'd4, 8'hFF, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 3'd1, 8'h00, 8'h81, 8'h81};
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ib;
            ib = i[7:0];
            src_mem[i] = ib ^ 8'h55;
        end

        // Reset state and release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_first_clk", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rst_ready_after", {31'd0, req_ready}, 32'd1);

        // Host access table
        for (int i = 0; i < 6; i++) begin
            do_host(i, vecs[i].rw, vecs[i].sel, vecs[i].wdata, vecs[i].pval, vecs[i].exp_rd);
        end

        // Manual DMA burst
        n0 = ev_q.size(); d0 = n_done; s0 = n_src_en;
        @(posedge clk); #1 dma_start = 1'b1;
        @(posedge clk); #1 dma_start = 1'b0;
        @(negedge clk);
        check("dma1_busy", {31'd0, dma_busy}, 32'd1);
        wait_done(4000, ok);
        check("dma1_done_seen", {31'd0, ok}, 32'd1);
        repeat (20) @(negedge clk);
        check("dma1_ev_count", ev_q.size(), n0 + 257);
        check("dma1_done_count", n_done, d0 + 1);
        check("dma1_src_en_count", n_src_en, s0 + 256);
        check("dma1_busy_end", {31'd0, dma_busy}, 32'd0);
        check("dma1_src_addr_wrap", {24'd0, src_addr}, 32'd0);
        if (ev_q.size() >= n0 + 257) check_burst("dma1", n0);
        $display("dma burst 1 complete: %0d bus cycles", ev_q.size() - n0);

        // NMI-triggered bursts: held low gives one burst, a new falling edge gives another
        n0 = ev_q.size(); d0 = n_done;
        dma_auto_en = 1'b1;
        @(posedge clk); #1 nmi_n = 1'b0;
        wait_done(4000, ok);
        check("nmi1_done_seen", {31'd0, ok}, 32'd1);
        repeat (1000) @(negedge clk);
        check("nmi1_done_count", n_done, d0 + 1);
        check("nmi1_ev_count", ev_q.size(), n0 + 257);
        check("nmi1_busy_idle", {31'd0, dma_busy}, 32'd0);
        @(posedge clk); #1 nmi_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 nmi_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 dma_start = 1'b1;
        @(posedge clk); #1 dma_start = 1'b0;
        repeat (50) @(negedge clk);
        check("nmi2_busy", {31'd0, dma_busy}, 32'd1);
        @(posedge clk); #1 dma_start = 1'b1;
        @(posedge clk); #1 dma_start = 1'b0;
        wait_done(4000, ok);
        check("nmi2_done_seen", {31'd0, ok}, 32'd1);
        repeat (300) @(negedge clk);
        check("nmi2_done_count", n_done, d0 + 2);
        check("nmi2_ev_count", ev_q.size(), n0 + 514);
        if (ev_q.size() >= n0 + 514) check_burst("nmi2", n0 + 257);
        nmi_n = 1'b1;
        dma_auto_en = 1'b0;
        $display("nmi bursts complete: %0d bursts", n_done - d0);

        // Host request raised together with dma_start: DMA first, request served once afterwards
        repeat (5) @(posedge clk);
        n0 = ev_q.size(); d0 = n_done;
        #1;
        dma_start = 1'b1;
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_reg   = 3'd1;
        req_wdata = 8'h77;
        @(negedge clk);
        check("prio_dma_wins_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1 dma_start = 1'b0;
        bad = 0; seen = 1'b0; acc = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (dma_done) seen = 1'b1;
            if (req_ready) begin
                if (!seen) bad++;
                else begin
                    acc = 1'b1;
                    break;
                end
            end
        end
        check("prio_ready_during_dma", bad, 0);
        check("prio_accepted_after_done", {31'd0, acc}, 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("prio_ev_count", ev_q.size(), n0 + 258);
        if (ev_q.size() >= n0 + 258) begin
            check("prio_first_is_dma", {29'd0, ev_q[n0].sel}, 32'd3);
            check("prio_host_sel", {29'd0, ev_q[n0 + 257].sel}, 32'd1);
            check("prio_host_data", {24'd0, ev_q[n0 + 257].data}, 32'h77);
            check("prio_host_we_b", {31'd0, ev_q[n0 + 257].we_b}, 32'd0);
        end
        check("prio_done_count", n_done, d0 + 1);

        // Asynchronous reset in the STROBE phase of a write
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_reg   = 3'd6;
        req_wdata = 8'h99;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst6_accept", {31'd0, ok}, 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst6_in_strobe", {31'd0, bus_phi2}, 32'd1);
        r0 = n_rsp; d0 = n_done; n0 = ev_q.size();
        #1 reset = 1'b1;
        #1;
        check_reset("rst6");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst6_ready_first_clk", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rst6_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (20) @(negedge clk);
        check("rst6_no_rsp", n_rsp, r0);
        check("rst6_no_done", n_done, d0);
        check("rst6_no_bus_cycle", ev_q.size(), n0);
        check("rst6_cs_idle", {31'd0, bus_cs}, 32'd0);
        do_host(6, 1'b1, 3'd2, 8'h00, 8'hE1, 8'hE1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
